// File: rtl/ppm16_rx_ctrl.sv
// PPM16 receive controller: gathers 16 chip counts, strobes the correlator, packs nibbles into bytes.
// Optional macro PPM16_ERASURE_CNT_EN adds a saturating 8-bit erasure counter output.
module ppm16_rx_ctrl #(
  parameter int CHIP_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CHIP_BITS-1:0]    chip_in,
  input  logic                    chip_valid,
  output logic [16*CHIP_BITS-1:0] chips_out,
  output logic                    corr_valid,
  input  logic [3:0]              symbol,
  input  logic                    threshold_unmet,
  output logic [7:0]              byte_out,
  output logic                    byte_erased,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    overflow
`ifdef PPM16_ERASURE_CNT_EN
  ,
  output logic [7:0]              erasure_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CORR    = 2'd2,
    PACK    = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [3:0]              idx_r;
  logic                    phase_r;
  logic [16*CHIP_BITS-1:0] chips_r;
  logic                    corr_valid_r;
  logic [3:0]              sym_r;
  logic                    miss_r;
  logic [3:0]              hi_nib_r;
  logic                    hi_miss_r;
  logic [7:0]              byte_out_r;
  logic                    byte_erased_r;
  logic                    byte_valid_r;
  logic                    overflow_r;
  logic                    byte_done_s;
  logic                    load_s;
  logic                    drop_s;

  // Next-state selection and byte completion / drop decisions.
  always_comb begin
    state_s     = state_r;
    byte_done_s = 1'b0;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    if (!en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = COLLECT;
        COLLECT: begin
          if (chip_valid && (idx_r == 4'd15)) begin
            state_s = CORR;
          end else begin
            state_s = COLLECT;
          end
        end
        CORR:    state_s = PACK;
        PACK:    state_s = COLLECT;
        default: state_s = IDLE;
      endcase
    end
    // A second nibble completes a byte only while reception stays enabled.
    if ((state_r == PACK) && en && phase_r) begin
      byte_done_s = 1'b1;
      load_s      = ~byte_valid_r | byte_ready;
      drop_s      = byte_valid_r & ~byte_ready;
    end else begin
      byte_done_s = 1'b0;
    end
  end

  // State register, chip slots, nibble packing and output byte holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      idx_r         <= 4'd0;
      phase_r       <= 1'b0;
      chips_r       <= '0;
      corr_valid_r  <= 1'b0;
      sym_r         <= 4'd0;
      miss_r        <= 1'b0;
      hi_nib_r      <= 4'd0;
      hi_miss_r     <= 1'b0;
      byte_out_r    <= 8'd0;
      byte_erased_r <= 1'b0;
      byte_valid_r  <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      corr_valid_r <= (state_s == CORR);
      case (state_r)
        IDLE: begin
          idx_r   <= 4'd0;
          phase_r <= 1'b0;
        end
        COLLECT: begin
          if (en && chip_valid) begin
            for (int k = 0; k < 16; k++) begin
              if (idx_r == 4'(k)) begin
                chips_r[k*CHIP_BITS +: CHIP_BITS] <= chip_in;
              end
            end
            idx_r <= idx_r + 4'd1;
          end
        end
        CORR: begin
          sym_r  <= symbol;
          miss_r <= threshold_unmet;
        end
        PACK: begin
          if (en) begin
            if (!phase_r) begin
              hi_nib_r  <= sym_r;
              hi_miss_r <= miss_r;
            end
            phase_r <= ~phase_r;
          end
        end
        default: ;
      endcase
      if (load_s) begin
        byte_out_r    <= {hi_nib_r, sym_r};
        byte_erased_r <= hi_miss_r | miss_r;
        byte_valid_r  <= 1'b1;
      end else if (byte_ready) begin
        byte_valid_r  <= 1'b0;
      end else begin
        byte_valid_r  <= byte_valid_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef PPM16_ERASURE_CNT_EN
  logic [7:0] erasure_cnt_r;

  // Count threshold misses seen during correlation, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      erasure_cnt_r <= 8'd0;
    end else if ((state_r == CORR) && threshold_unmet && (erasure_cnt_r != 8'hFF)) begin
      erasure_cnt_r <= erasure_cnt_r + 8'd1;
    end
  end

  assign erasure_cnt = erasure_cnt_r;
`endif

  assign chips_out   = chips_r;
  assign corr_valid  = corr_valid_r;
  assign byte_out    = byte_out_r;
  assign byte_erased = byte_erased_r;
  assign byte_valid  = byte_valid_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_ppm16_rx_ctrl.sv
// Directed bench for ppm16_rx_ctrl with a max-slot correlator stand-in (threshold: peak count >= 4).
module tb_ppm16_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  chip_in = 3'd0;
  logic        chip_valid = 1'b0;
  logic [47:0] chips_out;
  logic        corr_valid;
  logic [3:0]  symbol;
  logic        threshold_unmet;
  logic [7:0]  byte_out;
  logic        byte_erased;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        overflow;
`ifdef PPM16_ERASURE_CNT_EN
  logic [7:0]  erasure_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int gap = 0;
  int last_pulse = 0;
  int snap = 0;

  ppm16_rx_ctrl #(.CHIP_BITS(3)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .chip_in(chip_in),
    .chip_valid(chip_valid),
    .chips_out(chips_out),
    .corr_valid(corr_valid),
    .symbol(symbol),
    .threshold_unmet(threshold_unmet),
    .byte_out(byte_out),
    .byte_erased(byte_erased),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .overflow(overflow)
`ifdef PPM16_ERASURE_CNT_EN
    ,
    .erasure_cnt(erasure_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Correlator stand-in: first slot with the largest count wins.
  always_comb begin
    logic [2:0] bv;
    logic [3:0] best;
    bv   = 3'd0;
    best = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (chips_out[k*3 +: 3] > bv) begin
        bv   = chips_out[k*3 +: 3];
        best = 4'(k);
      end
    end
    symbol          = best;
    threshold_unmet = (bv < 3'd4);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (corr_valid) begin
      pulses     <= pulses + 1;
      gap        <= cyc - last_pulse;
      last_pulse <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chips16(input int pos, input logic [2:0] val);
    for (int k = 0; k < 16; k++) begin
      chip_valid = 1'b1;
      chip_in    = (k == pos) ? val : 3'd0;
      tick();
    end
    chip_valid = 1'b0;
    chip_in    = 3'd0;
  endtask

  task automatic frame(input int pos, input logic [2:0] val);
    chips16(pos, val);
    chk("corr_on", {63'd0, corr_valid}, 64'd1);
    tick();
    chk("corr_off_pack", {63'd0, corr_valid}, 64'd0);
    tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_chips", {16'd0, chips_out}, 64'd0);
    chk("rst_corr", {63'd0, corr_valid}, 64'd0);
    chk("rst_byte", {56'd0, byte_out}, 64'd0);
    chk("rst_erased", {63'd0, byte_erased}, 64'd0);
    chk("rst_valid", {63'd0, byte_valid}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);

    // Two symbol-5 frames -> byte 0x55
    byte_ready = 1'b1;
    en = 1'b1;
    tick();
    frame(5, 3'd7);
    chk("hi_only_valid", {63'd0, byte_valid}, 64'd0);
    frame(5, 3'd7);
    chk("b55_valid", {63'd0, byte_valid}, 64'd1);
    chk("b55_data", {56'd0, byte_out}, 64'h55);
    chk("b55_erased", {63'd0, byte_erased}, 64'd0);
    tick();
    chk("b55_valid_clr", {63'd0, byte_valid}, 64'd0);

    // Symbols 0xA then 0x3 with a threshold miss on the second -> 0xA3 erased
    frame(10, 3'd7);
    frame(3, 3'd2);
    chk("bA3_data", {56'd0, byte_out}, 64'hA3);
    chk("bA3_erased", {63'd0, byte_erased}, 64'd1);
    chk("bA3_valid", {63'd0, byte_valid}, 64'd1);
`ifdef PPM16_ERASURE_CNT_EN
    chk("erasure_cnt1", {56'd0, erasure_cnt}, 64'd1);
`endif
    tick();

    // Backpressure across four symbols: 0x12 held, 0x34 dropped
    byte_ready = 1'b0;
    frame(1, 3'd7);
    frame(2, 3'd7);
    frame(3, 3'd7);
    frame(4, 3'd7);
    chk("bp_data", {56'd0, byte_out}, 64'h12);
    chk("bp_valid", {63'd0, byte_valid}, 64'd1);
    chk("bp_ovf", {63'd0, overflow}, 64'd1);
    byte_ready = 1'b1;
    tick();
    chk("bp_valid_clr", {63'd0, byte_valid}, 64'd0);
    chk("bp_ovf_sticky", {63'd0, overflow}, 64'd1);
    chk("bp_data_kept", {56'd0, byte_out}, 64'h12);

    // en dropped after 9 chips, then a fresh frame becomes the high nibble
    snap = pulses;
    for (int k = 0; k < 9; k++) begin
      chip_valid = 1'b1;
      chip_in    = (k == 7) ? 3'd7 : 3'd0;
      tick();
    end
    en = 1'b0;
    chip_valid = 1'b0;
    chip_in = 3'd0;
    tick();
    tick();
    en = 1'b1;
    tick();
    frame(9, 3'd6);
    chk("abort_pulses", 64'(pulses - snap), 64'd1);
    frame(6, 3'd7);
    chk("abort_byte", {56'd0, byte_out}, 64'h96);
    chk("abort_valid", {63'd0, byte_valid}, 64'd1);
    tick();

    // Reset during CORR with a pending high nibble
    frame(4, 3'd7);
    chips16(8, 3'd7);
    chk("pre_rst_corr", {63'd0, corr_valid}, 64'd1);
    rst = 1'b1;
    en = 1'b0;
    tick();
    rst = 1'b0;
    chk("rc_chips", {16'd0, chips_out}, 64'd0);
    chk("rc_corr", {63'd0, corr_valid}, 64'd0);
    chk("rc_byte", {56'd0, byte_out}, 64'd0);
    chk("rc_erased", {63'd0, byte_erased}, 64'd0);
    chk("rc_valid", {63'd0, byte_valid}, 64'd0);
    chk("rc_ovf", {63'd0, overflow}, 64'd0);
`ifdef PPM16_ERASURE_CNT_EN
    chk("rc_erasure_cnt", {56'd0, erasure_cnt}, 64'd0);
`endif
    en = 1'b1;
    tick();
    chk("rc_no_byte", {63'd0, byte_valid}, 64'd0);

    // chip_valid held high for 54 cycles; CORR/PACK-time chips carry 7 and must not land
    snap = pulses;
    for (int i = 0; i < 54; i++) begin
      if (i == 40) chk("cont_gap_mid", 64'(gap), 64'd18);
      chip_valid = 1'b1;
      if ((i % 18) >= 16) chip_in = 3'd7;
      else if ((i % 18) == 2) chip_in = 3'd5;
      else chip_in = 3'd0;
      tick();
    end
    chip_valid = 1'b0;
    chip_in = 3'd0;
    chk("cont_pulses", 64'(pulses - snap), 64'd3);
    chk("cont_gap", 64'(gap), 64'd18);
    chk("cont_chips", {16'd0, chips_out}, 64'h140);
    chk("cont_byte", {56'd0, byte_out}, 64'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppm16_rx_ctrl.md
PPM16_RX_CTRL -- requirements
Module: ppm16_rx_ctrl

Interface
REQ-001 SHALL have parameter CHIP_BITS, default 3, giving the width of one chip count.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port en, input, 1, which enables reception; low forces IDLE.
REQ-005 SHALL have port chip_in, input, CHIP_BITS, the count for the current chip slot.
REQ-006 SHALL have port chip_valid, input, 1, which qualifies chip_in for one slot.
REQ-007 SHALL have port chips_out, output, 16*CHIP_BITS, to the correlator; slot k occupies bits [k*CHIP_BITS +: CHIP_BITS].
REQ-008 SHALL have port corr_valid, output, 1, the correlator input_valid strobe.
REQ-009 SHALL have port symbol, input, 4, the correlator result (combinational).
REQ-010 SHALL have port threshold_unmet, input, 1, the correlator threshold miss flag (combinational).
REQ-011 SHALL have port byte_out, output, 8, the assembled data byte.
REQ-012 SHALL have port byte_erased, output, 1, set if either nibble of byte_out came from a threshold miss.
REQ-013 SHALL have port byte_valid, output, 1, and byte_ready, input, 1, forming a valid/ready output handshake.
REQ-014 SHALL have port overflow, output, 1, a sticky flag set when a byte is dropped.

Function
REQ-015 SHALL implement states IDLE, COLLECT, CORR and PACK.
REQ-016 IDLE SHALL go to COLLECT when en=1 and SHALL clear the slot index and nibble phase.
REQ-017 In COLLECT, each cycle with chip_valid=1 SHALL write chip_in into slot[idx] and increment the 4-bit idx.
REQ-018 The write of slot 15 SHALL move the FSM to CORR on the next cycle, with idx wrapping to 0.
REQ-019 CORR SHALL last exactly one cycle with corr_valid=1; chips_out SHALL stay stable during it, and symbol/threshold_unmet SHALL be sampled at the end of that cycle.
REQ-020 corr_valid SHALL be 0 in every state other than CORR.
REQ-021 PACK (one cycle): on nibble phase 0, the sampled symbol SHALL become the high nibble; on phase 1, it SHALL become the low nibble and form a complete byte. Phase SHALL then toggle and the FSM SHALL return to COLLECT.
REQ-022 A complete byte SHALL load byte_out/byte_erased and set byte_valid in the cycle after PACK, if byte_valid is 0 or byte_ready is 1 in the PACK cycle.
REQ-023 Otherwise, the complete byte SHALL be dropped and overflow set; the held byte SHALL remain unchanged.
REQ-024 byte_valid SHALL clear one cycle after a byte_ready=1 cycle, unless a new byte loads in that same cycle.
REQ-025 byte_out and byte_erased SHALL be stable while byte_valid=1 and byte_ready=0.
REQ-026 chip_valid SHALL be ignored outside COLLECT; any chips presented during CORR or PACK SHALL be lost.
REQ-027 Minimum symbol period SHALL be 18 cycles (16 chips + CORR + PACK).
REQ-028 en=0 in any state SHALL return to IDLE on the next edge, discarding the partial chip frame and any pending high nibble; a held byte and overflow SHALL be kept.

Reset
REQ-029 On rst=1 at a clock edge, the following SHALL take effect on that edge, from any state and overriding en: state=IDLE, idx=0, phase=0, all slots=0, chips_out=0, corr_valid=0, byte_out=0, byte_erased=0, byte_valid=0, overflow=0.
REQ-030 rst SHALL be the only means of clearing overflow.

Configuration
REQ-031 With macro PPM16_ERASURE_CNT_EN defined, the block SHALL add output erasure_cnt (8 bits), which increments in each CORR cycle with threshold_unmet=1, saturates at 255, and is reset to 0.
REQ-032 Without PPM16_ERASURE_CNT_EN, the erasure_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Two frames, each with slot 5 = 7 and all other slots 0, correlator returning symbol 5 with threshold met, byte_ready=1 -> one byte_out=0x55, byte_erased=0, byte_valid high for 1 cycle.
REQ-034 Frames returning symbols 0xA then 0x3, with threshold_unmet=1 on the second -> byte_out=0xA3, byte_erased=1; with the macro defined, erasure_cnt=1.
REQ-035 byte_ready=0 across four complete symbols -> first byte held unchanged, second byte dropped, overflow=1 and still 1 after byte_ready rises.
REQ-036 en dropped after 9 chips, then restored and 16 fresh chips sent -> corr_valid fires exactly once, for the fresh frame only, as the high nibble.
REQ-037 rst asserted during CORR -> next cycle all outputs are 0 and state is IDLE; no byte is emitted.
REQ-038 chip_valid held high continuously for 54 cycles -> exactly 3 corr_valid pulses, spaced 18 cycles apart, with chips presented during CORR/PACK not captured.
